// File: rtl/cpu_fetch_pkg.sv
// cpu_fetch_pkg: shared branch encodings, reset PC and fetch FSM states
package cpu_fetch_pkg;
    localparam logic [1:0] BR_NONE = 2'b00;
    localparam logic [1:0] BR_COND = 2'b01;
    localparam logic [1:0] BR_J    = 2'b10;
    localparam logic [1:0] BR_JR   = 2'b11;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
    typedef enum logic {RUN, PEND} state_t;
endpackage

// File: rtl/npc_calc.sv
// npc_calc: combinational redirect target for conditional branches, j/jal and jr/jalr
module npc_calc
    import cpu_fetch_pkg::*;
(
    input  logic [31:0] d_pc,
    input  logic [15:0] imm16,
    input  logic [25:0] instr_index,
    input  logic [31:0] rs_val,
    input  logic [1:0]  br_type,
    output logic [31:0] target,
    output logic        misalign
);
    logic [31:0] br_tgt;
    logic [31:0] j_tgt;
    logic [31:0] jr_tgt;
    always_comb begin
        br_tgt   = d_pc + 32'd4 + {{14{imm16[15]}}, imm16, 2'b00};
        j_tgt    = {d_pc[31:28], instr_index, 2'b00};
        jr_tgt   = {rs_val[31:2], 2'b00};
        target   = (br_type == BR_JR) ? jr_tgt : (br_type == BR_J) ? j_tgt : br_tgt;
        misalign = (br_type == BR_JR) & (rs_val[1:0] != 2'b00);
    end
endmodule

// File: rtl/fetch_pc_seq.sv
// fetch_pc_seq: fetch-stage PC register, imem handshake and delay-slot redirect FSM
module fetch_pc_seq
    import cpu_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall,
    input  logic        br_valid,
    input  logic [1:0]  br_type,
    input  logic        cmp_out,
    input  logic [31:0] d_pc,
    input  logic [15:0] imm16,
    input  logic [25:0] instr_index,
    input  logic [31:0] rs_val,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    output logic        f_valid,
    output logic        pend_valid,
    output logic        err
);
    state_t      state, state_nx;
    logic [31:0] pc, pc_nx;
    logic [31:0] pend_target, pend_nx;
    logic        err_nx;
    logic [31:0] target;
    logic        misalign;
    logic        fire;
    logic        take;

    npc_calc u_npc (
        .d_pc        (d_pc),
        .imm16       (imm16),
        .instr_index (instr_index),
        .rs_val      (rs_val),
        .br_type     (br_type),
        .target      (target),
        .misalign    (misalign)
    );

    assign imem_req   = reset_n;
    assign imem_addr  = pc;
    assign fire       = imem_req & imem_ready & ~stall;
    assign f_valid    = fire;
    assign pend_valid = (state == PEND);
    assign take       = br_valid & ~stall &
                        ((br_type == BR_J) | (br_type == BR_JR) | ((br_type == BR_COND) & cmp_out));

    // The delay-slot fetch at pc always completes first; the redirect replaces the address after it.
    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        pend_nx  = pend_target;
        err_nx   = err;
        if (state == RUN) begin
            if (fire)
                pc_nx = take ? target : pc + 32'd4;
            else if (take) begin
                pend_nx  = target;
                state_nx = PEND;
            end
            if (take & misalign)
                err_nx = 1'b1;
        end else begin
            if (fire) begin
                pc_nx    = pend_target;
                state_nx = RUN;
            end
            if (br_valid & ~stall)
                err_nx = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= RUN;
            pc          <= RESET_PC;
            pend_target <= 32'd0;
            err         <= 1'b0;
        end else begin
            state       <= state_nx;
            pc          <= pc_nx;
            pend_target <= pend_nx;
            err         <= err_nx;
        end
    end
endmodule
